// File: rtl/ram_req_port_if.sv
// Request/response bundle between a requester and ram_req_port.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid & ready are both high;
// valid may not wait for ready, and the payload is only meaningful while valid is high.
interface ram_req_port_if #(
    parameter int AW = 10,
    parameter int NB = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [NB-1:0]     req_be;
    logic [AW-1:0]     req_addr;
    logic [NB*8-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [NB*8-1:0]   rsp_data;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_req_port.sv
// Front-end for a 2-cycle-latency byte-write RAM: drives the RAM port, tracks in-flight reads and
// buffers read data in a credit-protected response FIFO. Define RAM_REQ_PORT_STATS_EN for wr_cnt/rd_cnt.
module ram_req_port #(
    parameter int AW        = 10,
    parameter int NB        = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_req_port_if.slave     bus,
    output logic [NB-1:0]     ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [NB*8-1:0]   ram_din,
    input  logic [NB*8-1:0]   ram_dout
`ifdef RAM_REQ_PORT_STATS_EN
    ,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       rd_cnt
`endif
);
    localparam int DW = NB * 8;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;

    logic            r_rd_p1;
    logic            r_rd_p2;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [DW-1:0]   r_mem [RSP_DEPTH];

    logic [OW-1:0]   w_outstanding;
    logic            w_credit;
    logic            w_accept;
    logic            w_rd_acc;
    logic            w_wr_acc;
    logic            w_push;
    logic            w_pop;
    logic            w_rsp_valid;

    // A read only gets a credit if its datum is guaranteed a FIFO slot when it leaves the RAM pipeline.
    assign w_outstanding = OW'(r_count) + OW'(r_rd_p1) + OW'(r_rd_p2);
    assign w_credit      = w_outstanding < OW'(RSP_DEPTH);
    assign bus.req_ready = ~rst & (bus.req_we | w_credit);

    assign w_accept    = bus.req_valid & bus.req_ready;
    assign w_rd_acc    = w_accept & ~bus.req_we;
    assign w_wr_acc    = w_accept & bus.req_we;
    assign w_push      = r_rd_p2;
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;

    assign ram_addr = bus.req_addr;
    assign ram_din  = bus.req_wdata;
    assign ram_we   = w_wr_acc ? bus.req_be : '0;

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_p1  <= 1'b0;
            r_rd_p2  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_p1 <= w_rd_acc;
            r_rd_p2 <= r_rd_p1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            assert (!(w_push && !w_pop && (r_count == CW'(RSP_DEPTH))));
        end
    end

    // Storage needs no reset; only entries between the pointers are ever visible.
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wr_ptr] <= ram_dout;
    end

`ifdef RAM_REQ_PORT_STATS_EN
    logic [31:0] r_wr_cnt;
    logic [31:0] r_rd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr_acc) r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_rd_acc) r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign wr_cnt = r_wr_cnt;
    assign rd_cnt = r_rd_cnt;
`endif
endmodule

// File: tb/tb_ram_req_port.sv
// Bench for ram_req_port: behavioural RAM, directed vector table, multi-cycle corner sequences and
// random traffic checked against an address-array + response-queue model.
module tb_ram_req_port;
    localparam int AW    = 10;
    localparam int NB    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = NB * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_req_port_if #(.AW(AW), .NB(NB)) bus();
    logic [NB-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
`ifdef RAM_REQ_PORT_STATS_EN
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
`endif

    ram_req_port #(.AW(AW), .NB(NB), .RSP_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
`ifdef RAM_REQ_PORT_STATS_EN
        ,
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
`endif
    );

    // Block RAM: registered inputs, write commits one edge later, read data two cycles after the request.
    logic [DW-1:0] ram_arr [2**AW] = '{default: '0};
    logic [NB-1:0] s_we   = '0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_din  = '0;
    always @(posedge clk) begin
        if (|s_we) begin
            for (int b = 0; b < NB; b++)
                if (s_we[b]) ram_arr[s_addr][b*8 +: 8] <= s_din[b*8 +: 8];
        end else begin
            ram_dout <= ram_arr[s_addr];
        end
        s_we   <= ram_we;
        s_addr <= ram_addr;
        s_din  <= ram_din;
    end

    // Reference model and scoreboard
    logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
    logic [DW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_pop = 0;
    int pop_at [1024];
    bit acc_seen;
    bit rand_rdy = 1'b0;
    logic m_ready, m_rsp_valid;
    logic [DW-1:0] m_rsp_data;

    typedef struct {
        logic          we;
        logic [NB-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: observe at the falling edge, then return just after the next rising edge.
    task automatic tick();
        logic exp_rdy;
        logic acc;
        @(negedge clk);
        m_ready     = bus.req_ready;
        m_rsp_valid = bus.rsp_valid;
        m_rsp_data  = bus.rsp_data;
        exp_rdy = !rst && (bus.req_we || (exp_q.size() < DEPTH));
        check("req_ready", bus.req_ready, exp_rdy);
        acc = bus.req_valid && bus.req_ready;
        check("ram_we", ram_we, (acc && bus.req_we) ? bus.req_be : '0);
        if (rst) begin
            exp_q.delete();
            n_wr = 0;
            n_rd = 0;
        end else begin
            if (exp_q.size() == 0) check("no_stale_rsp", bus.rsp_valid, 1'b0);
            else if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_data", bus.rsp_data, exp_q.pop_front());
                if (n_pop < 1024) pop_at[n_pop] = cyc;
                n_pop++;
            end
            if (acc) begin
                if (bus.req_we) begin
                    for (int b = 0; b < NB; b++)
                        if (bus.req_be[b]) ref_mem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
                    n_wr++;
                end else begin
                    exp_q.push_back(ref_mem[bus.req_addr]);
                    n_rd++;
                end
            end
        end
        acc_seen = acc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_req(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (acc_seen) break;
            if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        check("req_accept", acc_seen, 1'b1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int got, r0, p0;
        tbl[0] = '{1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 4'h0, 10'h005, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 4'hF, 10'h010, 32'h11223344, 32'h0};
        tbl[3] = '{1'b1, 4'h2, 10'h010, 32'h0000AA00, 32'h0};
        tbl[4] = '{1'b0, 4'h0, 10'h010, 32'h0,        32'h1122AA44};
        tbl[5] = '{1'b1, 4'h0, 10'h020, 32'hCAFEF00D, 32'h0};
        tbl[6] = '{1'b0, 4'h0, 10'h020, 32'h0,        32'h00000000};
        tbl[7] = '{1'b1, 4'h9, 10'h020, 32'hA5A5A5A5, 32'h0};
        tbl[8] = '{1'b0, 4'h0, 10'h020, 32'h0,        32'hA50000A5};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", m_ready, 1'b0);
        check("rst_rsp_valid", m_rsp_valid, 1'b0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", m_ready, 1'b1);

        // Directed vectors: latency, read-after-write, partial and empty byte masks
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            do_req(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].we) begin
                got = 0;
                for (int k = 1; k <= 6; k++) begin
                    tick();
                    if (m_rsp_valid) begin
                        got = k;
                        break;
                    end
                end
                check("tbl_latency", got, 3);
                check("tbl_data", m_rsp_data, tbl[i].exp);
            end
        end

        // Credit exhaustion with stalled consumer
        for (int i = 0; i < 6; i++) do_req(1'b1, 4'hF, AW'(i), 32'hA0000000 + i);
        drain("drain_prefill");
        bus.rsp_ready = 1'b0;
        r0 = n_rd;
        for (int i = 0; i < 4; i++) do_req(1'b0, '0, AW'(i), '0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h004;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_ready", m_ready, 1'b0);
        end
        check("stall_accepts", n_rd - r0, 4);
        bus.req_valid = 1'b0;
        do_req(1'b1, 4'hF, 10'h3F0, 32'h5555AAAA);
        bus.rsp_ready = 1'b1;
        p0 = n_pop;
        do_req(1'b0, '0, 10'h004, '0);
        do_req(1'b0, '0, 10'h005, '0);
        drain("drain_stall");
        check("stall_responses", n_pop - p0, 6);

        // Streaming reads
        p0 = n_pop;
        for (int i = 0; i < 16; i++) do_req(1'b0, '0, AW'(10'h100 + i), '0);
        drain("drain_stream");
        check("stream_responses", n_pop - p0, 16);
        check("stream_span", pop_at[p0 + 15] - pop_at[p0], 15);

        // Reset with two reads in flight and two buffered
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_req(1'b0, '0, AW'(i), '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_rsp_valid", m_rsp_valid, 1'b0);
        check("midrst_ready", m_ready, 1'b1);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("midrst_no_stale", m_rsp_valid, 1'b0);
        end

        // Statistics window: 3 writes + 5 reads since the last reset
        for (int i = 0; i < 3; i++) do_req(1'b1, 4'hF, AW'(10'h300 + i), $urandom);
        for (int i = 0; i < 5; i++) do_req(1'b0, '0, AW'(10'h300 + i), '0);
        drain("drain_stats");
`ifdef RAM_REQ_PORT_STATS_EN
        check("wr_cnt", wr_cnt, 32'd3);
        check("rd_cnt", rd_cnt, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("wr_cnt_rst", wr_cnt, 32'd0);
        check("rd_cnt_rst", rd_cnt, 32'd0);
`endif

        // Random traffic over a small window so reads often hit recent writes
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) tick();
            else do_req(1'($urandom_range(0, 1)), NB'($urandom_range(0, 15)),
                        AW'(10'h200 + $urandom_range(0, 15)), $urandom);
        end
        rand_rdy = 1'b0;
        bus.rsp_ready = 1'b1;
        drain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
